// File: rtl/clk_src_sel_pkg.sv
// Shared types and encodings for the clock source select sequencer.
package clk_src_sel_pkg;

  typedef enum logic [1:0] {IDLE, PREP, SWITCH, DWELL} state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_NRDY = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Expected one-hot switch status once a given source is gated on
  function automatic logic [1:0] src_onehot(input logic src);
    return (src == SRC_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/clk_src_sel_ctrl_sync_cell.sv
// Multi-bit flop-chain synchronizer with synchronous active-low clear.
module sync_cell #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rstn) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_src_sel_ctrl.sv
// Sequencer owning the sel input of the A/B glitch-free clock switch.
// Optional auto-failover enabled by defining CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN.
module clk_src_sel_ctrl
  import clk_src_sel_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DWELL_CYC   = 64,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic       req_src,
  output logic       req_ready,
  output logic       sel,
  output logic       cur_src,
  output logic       busy,
  output logic       done_pulse,
  output logic       err_pulse,
  output logic [1:0] err_code,
  input  logic       src_rdy_A,
  input  logic       src_rdy_B,
  input  logic [1:0] sw_act
`ifdef CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN
  ,
  output logic       fo_pulse
`endif
);

  state_e           state_q, state_d;
  logic             tgt_q, tgt_d, sel_d, cur_d;
  logic             done_d, err_d, fo_d;
  logic [1:0]       code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       rdy_s, act_s;

  sync_cell #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_rdy (
    .clk(clk), .rstn(rstn), .d({src_rdy_B, src_rdy_A}), .q(rdy_s));
  sync_cell #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_act (
    .clk(clk), .rstn(rstn), .d(sw_act), .q(act_s));

  logic new_req, new_tgt, fo_trig;
  logic prep_go, prep_tmo, sw_ok, sw_tmo, dwell_end;

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign prep_go   = rdy_s[tgt_q];
  assign prep_tmo  = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  assign sw_ok     = act_s == src_onehot(tgt_q);
  assign sw_tmo    = prep_tmo;
  assign dwell_end = cnt_q == CNT_W'(DWELL_CYC - 1);

`ifdef CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN
  logic [1:0] lo_cnt;
  logic       fo_q;

  // Counts consecutive idle cycles with the current source's rdy low
  always_ff @(posedge clk) begin
    if (!rstn)                                     lo_cnt <= '0;
    else if (state_q != IDLE || rdy_s[cur_src])    lo_cnt <= '0;
    else if (lo_cnt != 2'd3)                       lo_cnt <= lo_cnt + 2'd1;
  end

  assign fo_trig  = (state_q == IDLE) && !req_valid && !rdy_s[cur_src] &&
                    (lo_cnt == 2'd3) && rdy_s[~cur_src];
  assign fo_pulse = fo_q;

  always_ff @(posedge clk) begin
    if (!rstn) fo_q <= 1'b0;
    else       fo_q <= fo_d;
  end
`else
  assign fo_trig = 1'b0;
`endif

  assign new_req = (state_q == IDLE) && (req_valid || fo_trig);
  assign new_tgt = req_valid ? req_src : ~cur_src;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_req && new_tgt != cur_src) state_d = PREP;
      PREP:    if (prep_go || prep_tmo)           state_d = prep_go ? SWITCH : IDLE;
      SWITCH:  if (sw_ok || sw_tmo)               state_d = sw_ok ? DWELL : IDLE;
      DWELL:   if (dwell_end)                     state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    tgt_d  = tgt_q;
    sel_d  = sel;
    cur_d  = cur_src;
    cnt_d  = cnt_inc;
    done_d = 1'b0;
    err_d  = 1'b0;
    fo_d   = 1'b0;
    code_d = ERR_NONE;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (new_req) begin
          tgt_d  = new_tgt;
          done_d = new_tgt == cur_src;
          fo_d   = !req_valid;
        end
      end
      PREP: begin
        if (prep_go) begin
          sel_d = tgt_q;
          cnt_d = '0;
        end else if (prep_tmo) begin
          err_d  = 1'b1;
          code_d = ERR_NRDY;
        end
      end
      SWITCH: begin
        if (sw_ok) begin
          cur_d = tgt_q;
          cnt_d = '0;
        end else if (sw_tmo) begin
          sel_d  = cur_src;
          err_d  = 1'b1;
          code_d = ERR_TMO;
        end
      end
      DWELL:   done_d = dwell_end;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tgt_q      <= SRC_A;
      sel        <= SRC_A;
      cur_src    <= SRC_A;
      cnt_q      <= '0;
      done_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      tgt_q      <= tgt_d;
      sel        <= sel_d;
      cur_src    <= cur_d;
      cnt_q      <= cnt_d;
      done_pulse <= done_d;
      err_pulse  <= err_d;
      err_code   <= code_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_clk_src_sel_ctrl.sv
// Directed self-checking bench for clk_src_sel_ctrl (default parameters).
module tb_clk_src_sel_ctrl;

  logic       clk = 1'b0;
  logic       rstn, req_valid, req_src, req_ready, sel, cur_src, busy;
  logic       done_pulse, err_pulse, src_rdy_A, src_rdy_B;
  logic [1:0] err_code, sw_act;
`ifdef CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN
  logic       fo_pulse;
`endif

  int checks = 0;
  int failures = 0;

  clk_src_sel_ctrl dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_src(req_src),
    .req_ready(req_ready), .sel(sel), .cur_src(cur_src), .busy(busy),
    .done_pulse(done_pulse), .err_pulse(err_pulse), .err_code(err_code),
    .src_rdy_A(src_rdy_A), .src_rdy_B(src_rdy_B), .sw_act(sw_act)
`ifdef CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN
    , .fo_pulse(fo_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = 1'b0; req_src = 1'b0;
    sw_act = 2'b01;
    tick(2);
    rstn = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    src_rdy_A = 1'b1; src_rdy_B = 1'b1;
    rstn = 1'b0; req_valid = 1'b0; req_src = 1'b0; sw_act = 2'b01;
    tick(2);
    rstn = 1'b1;
    checks++;
    if ({sel, cur_src, req_ready, busy, done_pulse, err_pulse, err_code} !== 8'b0010_0000) begin
      failures++;
      $display("FAIL reset_state got sel=%b cur=%b rdy=%b busy=%b done=%b err=%b code=%b exp 0 0 1 0 0 0 00",
               sel, cur_src, req_ready, busy, done_pulse, err_pulse, err_code);
    end
    tick(3);
  endtask

  task automatic test_same_src();
    req_valid = 1'b1; req_src = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({done_pulse, sel, busy, req_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL same_src got done=%b sel=%b busy=%b rdy=%b exp 1 0 0 1",
               done_pulse, sel, busy, req_ready);
    end
    tick();
    checks++;
    if (done_pulse !== 1'b0) begin
      failures++;
      $display("FAIL same_src_pulse_len got done=%b exp 0", done_pulse);
    end
  endtask

  task automatic test_switch_b();
    int  wait_n;
    logic bad;
    req_valid = 1'b1; req_src = 1'b1;
    tick();
    req_valid = 1'b0; req_src = 1'b0;
    checks++;
    if ({busy, req_ready, sel} !== 3'b100) begin
      failures++;
      $display("FAIL switch_prep got busy=%b rdy=%b sel=%b exp 1 0 0", busy, req_ready, sel);
    end
    tick();
    checks++;
    if (sel !== 1'b1) begin
      failures++;
      $display("FAIL switch_sel got sel=%b exp 1", sel);
    end
    sw_act = 2'b00;
    tick(5);
    checks++;
    if ({cur_src, busy} !== 2'b01) begin
      failures++;
      $display("FAIL switch_gap got cur=%b busy=%b exp 0 1", cur_src, busy);
    end
    sw_act = 2'b10;
    wait_n = 0;
    while (cur_src !== 1'b1 && wait_n < 20) begin
      tick();
      wait_n++;
    end
    checks++;
    if (wait_n != 3) begin
      failures++;
      $display("FAIL switch_confirm got cycles=%0d exp 3", wait_n);
    end
    bad = 1'b0;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (done_pulse !== 1'b0 || req_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL switch_dwell got early done or ready exp none");
    end
    tick();
    checks++;
    if ({done_pulse, err_pulse, cur_src, sel} !== 4'b1011) begin
      failures++;
      $display("FAIL switch_done got done=%b err=%b cur=%b sel=%b exp 1 0 1 1",
               done_pulse, err_pulse, cur_src, sel);
    end
    tick();
    checks++;
    if ({done_pulse, busy, req_ready} !== 3'b001) begin
      failures++;
      $display("FAIL switch_idle got done=%b busy=%b rdy=%b exp 0 0 1", done_pulse, busy, req_ready);
    end
  endtask

  task automatic test_same_src_b();
    req_valid = 1'b1; req_src = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({done_pulse, sel, cur_src, busy} !== 4'b1110) begin
      failures++;
      $display("FAIL same_src_b got done=%b sel=%b cur=%b busy=%b exp 1 1 1 0",
               done_pulse, sel, cur_src, busy);
    end
    tick();
  endtask

  task automatic test_mid_dwell_reset();
    int   wait_n;
    logic bad;
    do_reset();
    req_valid = 1'b1; req_src = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    sw_act = 2'b10;
    wait_n = 0;
    while (cur_src !== 1'b1 && wait_n < 20) begin
      tick();
      wait_n++;
    end
    tick(10);
    checks++;
    if ({busy, cur_src} !== 2'b11) begin
      failures++;
      $display("FAIL dwell_entry got busy=%b cur=%b exp 1 1", busy, cur_src);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({sel, cur_src, busy, req_ready, done_pulse} !== 5'b00010) begin
      failures++;
      $display("FAIL dwell_reset got sel=%b cur=%b busy=%b rdy=%b done=%b exp 0 0 0 1 0",
               sel, cur_src, busy, req_ready, done_pulse);
    end
    rstn = 1'b1;
    sw_act = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done_pulse !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL dwell_reset_drop got done or busy after reset exp quiet");
    end
  endtask

  task automatic test_nrdy();
    int wait_n;
    src_rdy_B = 1'b0;
    tick(3);
    req_valid = 1'b1; req_src = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_n = 0;
    while (err_pulse !== 1'b1 && wait_n < 1100) begin
      tick();
      wait_n++;
      if (done_pulse === 1'b1) break;
    end
    checks++;
    if (wait_n != 1024) begin
      failures++;
      $display("FAIL nrdy_latency got cycles=%0d exp 1024", wait_n);
    end
    checks++;
    if ({err_pulse, done_pulse, err_code, sel, busy} !== 6'b10_01_00) begin
      failures++;
      $display("FAIL nrdy_result got err=%b done=%b code=%b sel=%b busy=%b exp 1 0 01 0 0",
               err_pulse, done_pulse, err_code, sel, busy);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b0) begin
      failures++;
      $display("FAIL nrdy_pulse_len got err=%b exp 0", err_pulse);
    end
    src_rdy_B = 1'b1;
    tick(3);
  endtask

  task automatic test_timeout();
    int wait_n;
    sw_act = 2'b01;
    req_valid = 1'b1; req_src = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (sel !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sel got sel=%b exp 1", sel);
    end
    wait_n = 0;
    while (err_pulse !== 1'b1 && wait_n < 1100) begin
      tick();
      wait_n++;
      if (done_pulse === 1'b1) break;
    end
    checks++;
    if (wait_n != 1024) begin
      failures++;
      $display("FAIL tmo_latency got cycles=%0d exp 1024", wait_n);
    end
    checks++;
    if ({err_pulse, done_pulse, err_code, sel, cur_src, busy} !== 7'b10_10_000) begin
      failures++;
      $display("FAIL tmo_result got err=%b done=%b code=%b sel=%b cur=%b busy=%b exp 1 0 10 0 0 0",
               err_pulse, done_pulse, err_code, sel, cur_src, busy);
    end
    tick();
  endtask

`ifdef CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN
  task automatic test_failover();
    int wait_n;
    do_reset();
    src_rdy_A = 1'b0; src_rdy_B = 1'b1;
    wait_n = 0;
    while (fo_pulse !== 1'b1 && wait_n < 20) begin
      tick();
      wait_n++;
    end
    checks++;
    if (wait_n != 6) begin
      failures++;
      $display("FAIL fo_latency got cycles=%0d exp 6", wait_n);
    end
    tick();
    checks++;
    if ({fo_pulse, sel} !== 2'b01) begin
      failures++;
      $display("FAIL fo_sel got fo=%b sel=%b exp 0 1", fo_pulse, sel);
    end
    sw_act = 2'b10;
    wait_n = 0;
    while (done_pulse !== 1'b1 && wait_n < 200) begin
      tick();
      wait_n++;
    end
    checks++;
    if ({done_pulse, cur_src} !== 2'b11) begin
      failures++;
      $display("FAIL fo_done got done=%b cur=%b exp 1 1", done_pulse, cur_src);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_same_src();
    test_switch_b();
    test_same_src_b();
    test_mid_dwell_reset();
    test_nrdy();
    test_timeout();
`ifdef CLK_SRC_SEL_CTRL_AUTO_FAILOVER_EN
    test_failover();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
